// File: rtl/dcache_pkg.sv
// dcache_pkg: shared constants and FSM encoding for the direct-mapped
// write-back data cache. Field constants describe the default geometry
// (32 lines x 256-bit blocks); the controller derives its own widths from
// its parameters so that other geometries stay consistent.
package dcache_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;    // bits [1:0] of a byte address
  localparam int BLOCK_BITS = 256;
  localparam int OFF_W      = 3;    // word offset within a block
  localparam int IDX_W      = 5;    // line index
  localparam int TAG_W      = 22;

  // Bit positions of each address field for the default geometry.
  localparam int OFF_LSB = BYTE_OFF_W;       // [4:2]
  localparam int IDX_LSB = OFF_LSB + OFF_W;  // [9:5]
  localparam int TAG_LSB = IDX_LSB + IDX_W;  // [31:10]

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_REFILL    = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// dcache_array: per-line valid/dirty/tag/data storage. One combinational
// read port, one full-line write port (refill) and one word write port
// (store hit). The two write ports are never active in the same cycle.
module dcache_array #(
  parameter int NUM_LINES = 32,
  parameter int WORDS     = 8,
  parameter int TAG_BITS  = 22,
  localparam int IDX_BITS = $clog2(NUM_LINES),
  localparam int OFF_BITS = $clog2(WORDS)
) (
  input  logic                         clk,
  input  logic                         reset,
  // read port
  input  logic [IDX_BITS-1:0]          rd_idx_i,
  output logic                         rd_valid_o,
  output logic                         rd_dirty_o,
  output logic [TAG_BITS-1:0]          rd_tag_o,
  output logic [WORDS-1:0][31:0]       rd_data_o,
  // line write port (refill): installs a clean, valid line
  input  logic                         line_we_i,
  input  logic [IDX_BITS-1:0]          line_idx_i,
  input  logic [TAG_BITS-1:0]          line_tag_i,
  input  logic [WORDS-1:0][31:0]       line_data_i,
  // word write port (store hit): updates one word and marks the line dirty
  input  logic                         word_we_i,
  input  logic [IDX_BITS-1:0]          word_idx_i,
  input  logic [OFF_BITS-1:0]          word_off_i,
  input  logic [31:0]                  word_data_i
);

  logic [NUM_LINES-1:0]    valid_q;
  logic [NUM_LINES-1:0]    dirty_q;
  logic [TAG_BITS-1:0]     tag_q  [NUM_LINES];
  logic [WORDS-1:0][31:0]  data_q [NUM_LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  // Status bits: cleared by reset, set by refill and store hits.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (line_we_i) begin
        valid_q[line_idx_i] <= 1'b1;
        dirty_q[line_idx_i] <= 1'b0;
      end
      if (word_we_i) begin
        dirty_q[word_idx_i] <= 1'b1;
      end
    end
  end

  // Tag and data storage: written by refill or by a store hit.
  // NOTE: no reset on the tag/data arrays; valid_q gates their use, and
  // leaving them unreset lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (line_we_i) begin
      tag_q[line_idx_i]  <= line_tag_i;
      data_q[line_idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[word_idx_i][word_off_i] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache
// for the MEM stage. Misses stall the pipeline while a dirty victim is
// written back and the missing block is fetched from block memory.
// Optional macro DCACHE_STATS_EN: enables saturating hit/miss counters;
// when undefined the counter ports are tied to zero.
module dcache_controller #(
  parameter int NUM_LINES  = 32,
  parameter int BLOCK_BITS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_read_i,
  input  logic                  cpu_write_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [31:0]           cpu_wdata_i,
  output logic [31:0]           cpu_rdata_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [BLOCK_BITS-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [BLOCK_BITS-1:0] mem_rdata_i,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o
);
  import dcache_pkg::*;

  localparam int WORDS    = BLOCK_BITS / WORD_W;
  localparam int OFF_BITS = $clog2(WORDS);
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int BLK_LSB  = OFF_BITS + BYTE_OFF_W;
  localparam int TAG_BITS = 32 - IDX_BITS - BLK_LSB;

  state_t state_q, state_d;

  logic [OFF_BITS-1:0]    addr_off;
  logic [IDX_BITS-1:0]    addr_idx;
  logic [TAG_BITS-1:0]    addr_tag;
  logic                   req;
  logic                   hit;
  logic                   line_valid;
  logic                   line_dirty;
  logic [TAG_BITS-1:0]    line_tag;
  logic [WORDS-1:0][31:0] line_data;
  logic [WORDS-1:0][31:0] refill_q;
  logic                   line_we;
  logic                   word_we;
  logic                   unused_byte_off;

  assign addr_off        = cpu_addr_i[BYTE_OFF_W +: OFF_BITS];
  assign addr_idx        = cpu_addr_i[BLK_LSB +: IDX_BITS];
  assign addr_tag        = cpu_addr_i[31 -: TAG_BITS];
  assign unused_byte_off = ^cpu_addr_i[BYTE_OFF_W-1:0];

  // A simultaneous read and write strobe is handled as a write.
  assign req = cpu_read_i | cpu_write_i;
  assign hit = req && line_valid && (line_tag == addr_tag);

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .WORDS     (WORDS),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .clk         (clk),
    .reset       (reset),
    .rd_idx_i    (addr_idx),
    .rd_valid_o  (line_valid),
    .rd_dirty_o  (line_dirty),
    .rd_tag_o    (line_tag),
    .rd_data_o   (line_data),
    .line_we_i   (line_we),
    .line_idx_i  (addr_idx),
    .line_tag_i  (addr_tag),
    .line_data_i (refill_q),
    .word_we_i   (word_we),
    .word_idx_i  (addr_idx),
    .word_off_i  (addr_off),
    .word_data_i (cpu_wdata_i)
  );

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Refill buffer: captures the fetched block in the ack cycle.
  always_ff @(posedge clk) begin
    if (state_q == ST_ALLOCATE && mem_ack_i) refill_q <= mem_rdata_i;
  end

  // Next-state, handshake and CPU-side outputs. Outputs are forced to zero
  // while reset is asserted so an abandoned transaction drops immediately.
  // NOTE: every output of this block is defaulted first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    cpu_rdata_o = '0;
    line_we     = 1'b0;
    word_we     = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            if (!cpu_write_i) cpu_rdata_o = line_data[addr_off];
            word_we = cpu_write_i;
          end else if (req) begin
            stall_o = 1'b1;
            state_d = (line_valid && line_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
        ST_WRITEBACK: begin
          stall_o     = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = {line_tag, addr_idx, {BLK_LSB{1'b0}}};
          mem_wdata_o = line_data;
          if (mem_ack_i) state_d = ST_ALLOCATE;
        end
        ST_ALLOCATE: begin
          stall_o    = 1'b1;
          mem_req_o  = 1'b1;
          mem_addr_o = {cpu_addr_i[31:BLK_LSB], {BLK_LSB{1'b0}}};
          if (mem_ack_i) state_d = ST_REFILL;
        end
        ST_REFILL: begin
          stall_o = 1'b1;
          line_we = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        after_refill_q;

  // Saturating statistics; the hit that follows a refill belongs to the
  // miss already counted and is skipped.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
      after_refill_q <= 1'b0;
    end else begin
      if (state_q == ST_REFILL)    after_refill_q <= 1'b1;
      else if (state_q == ST_IDLE) after_refill_q <= 1'b0;
      if (state_q == ST_IDLE && hit && !after_refill_q && hit_cnt_q != '1)
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == ST_IDLE && req && !hit && miss_cnt_q != '1)
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`else
  assign hit_count_o  = '0;
  assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed stimulus with a scoreboard. Stimulus
// pushes expected memory requests and load results into a queue; a monitor
// pops and compares whenever the DUT starts a memory request or completes
// a load. A behavioural block memory answers requests after LAT cycles.
module tb_dcache_controller;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [31:0] addr;
    int          wsel;
    logic [31:0] word;
    string       name;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         cpu_read_i, cpu_write_i;
  logic [31:0]  cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic         stall_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o, mem_rdata_i;
  logic [31:0]  hit_count_o, miss_count_o;

  int n_vec = 0;
  int n_err = 0;
  exp_t exp_q[$];

  localparam int LAT = 5;
  logic [255:0] mem_model [logic [31:0]];
  bit mem_hold = 0;
  int late_req = 0;
  int late_done = 0;

  dcache_controller dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_read_i   (cpu_read_i),
    .cpu_write_i  (cpu_write_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .hit_count_o  (hit_count_o),
    .miss_count_o (miss_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input int n);
`ifdef DCACHE_STATS_EN
    return 32'(n);
`else
    return 32'(0 * n);
`endif
  endfunction

  // Unwritten blocks read as 0xA000_0000 + byte address of each word.
  function automatic logic [255:0] fetch(input logic [31:0] a);
    logic [7:0][31:0] b;
    if (mem_model.exists(a)) return mem_model[a];
    for (int i = 0; i < 8; i++) b[i] = 32'hA000_0000 + a + 32'(i * 4);
    return b;
  endfunction

  task automatic exp_mem(input bit we, input logic [31:0] a, input int wsel,
                         input logic [31:0] w, input string nm);
    exp_t e;
    e.is_mem = 1'b1; e.we = we; e.addr = a; e.wsel = wsel; e.word = w; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic exp_load(input logic [31:0] w, input string nm);
    exp_t e;
    e.is_mem = 1'b0; e.we = 1'b0; e.addr = '0; e.wsel = 0; e.word = w; e.name = nm;
    exp_q.push_back(e);
  endtask

  // One CPU access held until the stall clears; checks the stall length.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input int exp_stall, input string nm);
    int stalls = 0;
    bit done = 0;
    @(posedge clk); #1;
    cpu_read_i = rd; cpu_write_i = wr; cpu_addr_i = a; cpu_wdata_i = wd;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      else done = 1;
    end
    check({nm, " completes"}, 256'(done), 256'(1));
    check({nm, " stall cycles"}, 256'(stalls), 256'(exp_stall));
    @(posedge clk); #1;
    cpu_read_i = 1'b0; cpu_write_i = 1'b0;
  endtask

  // Block memory responder: acks the LAT-th cycle of each request.
  initial begin
    int cnt = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk); #2;
      mem_ack_i = 1'b0;
      if (late_req != late_done) begin
        late_done = late_req;
        mem_ack_i = 1'b1;
        mem_rdata_i = {8{32'h5A5A_5A5A}};
      end else if (mem_req_o && !mem_hold && !reset) begin
        if (cnt == LAT - 1) begin
          cnt = 0;
          mem_ack_i = 1'b1;
          if (mem_we_o) mem_model[mem_addr_o] = mem_wdata_o;
          else          mem_rdata_i = fetch(mem_addr_o);
        end else begin
          cnt++;
        end
      end else if (!mem_req_o) begin
        cnt = 0;
      end
    end
  end

  // Monitor: compares each new memory request and each completed load.
  initial begin
    bit in_txn = 0;
    logic [31:0] cap_addr;
    logic [7:0][31:0] wd;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_txn = 0;
      end else begin
        if (mem_req_o && !in_txn) begin
          in_txn = 1;
          cap_addr = mem_addr_o;
          if (exp_q.size() == 0) begin
            check("unexpected mem request", 256'(mem_addr_o), 256'(32'hFFFF_FFFF));
          end else begin
            e = exp_q.pop_front();
            check({e.name, " is mem req"}, 256'(1), 256'(e.is_mem));
            check({e.name, " mem_we"}, 256'(mem_we_o), 256'(e.we));
            check({e.name, " mem_addr"}, 256'(mem_addr_o), 256'(e.addr));
            if (e.we) begin
              wd = mem_wdata_o;
              check({e.name, " wb word"}, 256'(wd[e.wsel]), 256'(e.word));
            end
          end
        end
        if (in_txn && mem_ack_i) begin
          check("mem_addr stable to ack", 256'(mem_addr_o), 256'(cap_addr));
          in_txn = 0;
        end
        if (cpu_read_i && !cpu_write_i && !stall_o) begin
          if (exp_q.size() == 0) begin
            check("unexpected load", 256'(cpu_rdata_o), 256'(32'hFFFF_FFFF));
          end else begin
            e = exp_q.pop_front();
            check({e.name, " is load"}, 256'(0), 256'(e.is_mem));
            check({e.name, " rdata"}, 256'(cpu_rdata_o), 256'(e.word));
          end
        end
      end
    end
  end

  initial begin
    logic [7:0][31:0] b40;
    for (int i = 0; i < 8; i++) b40[i] = 32'h1111_0000 + 32'(i);
    b40[2] = 32'hDEAD_BEEF;
    mem_model[32'h40] = b40;

    reset = 1'b1;
    cpu_read_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset stall", 256'(stall_o), 256'(0));
    check("reset mem_req", 256'(mem_req_o), 256'(0));
    check("reset mem_addr", 256'(mem_addr_o), 256'(0));
    check("reset mem_wdata", mem_wdata_o, 256'(0));
    check("reset hit_count", 256'(hit_count_o), 256'(0));
    check("reset miss_count", 256'(miss_count_o), 256'(0));
    @(posedge clk); #1 reset = 1'b0;

    // Clean miss, then hits on the refilled line.
    exp_mem(0, 32'h40, 0, 0, "alloc 0x40");
    exp_load(32'h1111_0000, "load 0x40");
    do_access(1, 0, 32'h40, 0, 7, "load miss 0x40");
    exp_load(32'hDEAD_BEEF, "load 0x48");
    do_access(1, 0, 32'h48, 0, 0, "load hit 0x48");
    do_access(0, 1, 32'h44, 32'h1234_5678, 0, "store hit 0x44");
    exp_load(32'h1234_5678, "load 0x44");
    do_access(1, 0, 32'h44, 0, 0, "load hit 0x44");

    // Dirty victim: writeback of 0x40 then allocate 0x440.
    exp_mem(1, 32'h40, 1, 32'h1234_5678, "wb 0x40");
    exp_mem(0, 32'h440, 0, 0, "alloc 0x440");
    exp_load(32'hA000_0444, "load 0x444");
    do_access(1, 0, 32'h444, 0, 12, "load dirty miss 0x444");
    @(negedge clk);
    check("hit_count 3", 256'(hit_count_o), 256'(stat_exp(3)));
    check("miss_count 2", 256'(miss_count_o), 256'(stat_exp(2)));

    // Store miss with both strobes high (treated as a write).
    exp_mem(0, 32'h800, 0, 0, "alloc 0x800");
    do_access(1, 1, 32'h80C, 32'hCAFE_F00D, 7, "store miss 0x80C");
    exp_load(32'hCAFE_F00D, "load 0x80C");
    do_access(1, 0, 32'h80C, 0, 0, "load hit 0x80C");
    exp_load(32'hA000_0808, "load 0x808");
    do_access(1, 0, 32'h808, 0, 0, "load hit 0x808");

    // Evict 0x800: stored word must appear in slot 3 of the writeback.
    exp_mem(1, 32'h800, 3, 32'hCAFE_F00D, "wb 0x800");
    exp_mem(0, 32'h1000, 0, 0, "alloc 0x1000");
    exp_load(32'hA000_1000, "load 0x1000");
    do_access(1, 0, 32'h1000, 0, 12, "load dirty miss 0x1000");
    exp_mem(0, 32'h800, 0, 0, "realloc 0x800");
    exp_load(32'hCAFE_F00D, "reload 0x80C");
    do_access(1, 0, 32'h80C, 0, 7, "load clean miss 0x80C");
    @(negedge clk);
    check("hit_count 5", 256'(hit_count_o), 256'(stat_exp(5)));
    check("miss_count 5", 256'(miss_count_o), 256'(stat_exp(5)));

    // Reset while ALLOCATE waits for its ack.
    mem_hold = 1;
    exp_mem(0, 32'h2000, 0, 0, "alloc 0x2000");
    @(posedge clk); #1;
    cpu_read_i = 1'b1; cpu_addr_i = 32'h2000;
    repeat (3) @(negedge clk);
    check("alloc pending req", 256'(mem_req_o), 256'(1));
    check("alloc pending stall", 256'(stall_o), 256'(1));
    @(posedge clk); #1;
    reset = 1'b1; cpu_read_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post-reset mem_req", 256'(mem_req_o), 256'(0));
    check("post-reset stall", 256'(stall_o), 256'(0));
    check("post-reset mem_addr", 256'(mem_addr_o), 256'(0));
    @(posedge clk); #1;
    reset = 1'b0; mem_hold = 0;
    late_req++;
    repeat (3) @(negedge clk);
    check("late ack mem_req", 256'(mem_req_o), 256'(0));
    check("late ack stall", 256'(stall_o), 256'(0));
    check("reset hit_count", 256'(hit_count_o), 256'(0));
    check("reset miss_count", 256'(miss_count_o), 256'(0));

    // Valid bits were cleared: 0x44 misses, data comes from the writeback.
    exp_mem(0, 32'h40, 0, 0, "alloc 0x40 after reset");
    exp_load(32'h1234_5678, "load 0x44 after reset");
    do_access(1, 0, 32'h44, 0, 7, "load miss 0x44 after reset");
    exp_load(32'hDEAD_BEEF, "load 0x48 after reset");
    do_access(1, 0, 32'h48, 0, 0, "load hit 0x48 after reset");
    @(negedge clk);
    check("hit_count 1", 256'(hit_count_o), 256'(stat_exp(1)));
    check("miss_count 1", 256'(miss_count_o), 256'(stat_exp(1)));

    repeat (4) @(negedge clk);
    check("scoreboard drained", 256'(exp_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
